// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed 4-digit seven-segment scanner. Steps a 2-bit digit index
//   (select) through the upstream digit selector. It samples the returned digit
//   code once per slot, after a dead-time blanking interval, and then drives
//   the segment pattern and the matching active-low digit enable.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   decimal_digit  digit code from upstream for the current select
//   lz_blank       blank the tens digit (select 3) when its code is 0
//   dp_enable      light the decimal point on the ones digit (select 2)
//   blank_all      force all digit enables off (scan keeps running)
//   select         digit index to upstream (0 unit, 1 tenths, 2 ones, 3 tens)
//   digit_en       active-low digit enables, bit n drives digit n
//   segments       active-low {g,f,e,d,c,b,a}
//   dp             active-low decimal point
//   frame_done     one-cycle pulse after select wraps 3 -> 0
module seg_scan_driver #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] decimal_digit,
  input  logic       lz_blank,
  input  logic       dp_enable,
  input  logic       blank_all,
  output logic [1:0] select,
  output logic [3:0] digit_en,
  output logic [6:0] segments,
  output logic       dp,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] CntLast    = CNT_W'(TICK_DIV - 1);
  // The capture happens on the edge that leaves the last blanking cycle.
  localparam logic [CNT_W-1:0] CntCapture = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [1:0] SelOnes = 2'd2;
  localparam logic [1:0] SelTens = 2'd3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       select_q, select_d;
  logic [3:0]       digit_en_q, digit_en_d;
  logic [6:0]       segments_q, segments_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic slot_end;
  logic capture;

  // Active-low {g,f,e,d,c,b,a}. 10..12 are the C/H/I symbols. 13..15 are dark.
  function automatic logic [6:0] encode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      4'd10:   seg = 7'h46;
      4'd11:   seg = 7'h09;
      4'd12:   seg = 7'h79;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign slot_end = (cnt_q == CntLast);
  assign capture  = (cnt_q == CntCapture);

  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    select_d     = select_q;
    digit_en_d   = digit_en_q;
    segments_d   = segments_q;
    dp_d         = dp_q;
    frame_done_d = 1'b0;

    // Slot start: go dark in the same edge as select advances, so the
    // upstream settling time is hidden behind the blanking interval.
    if (slot_end) begin
      cnt_d        = '0;
      select_d     = select_q + 2'd1;
      digit_en_d   = 4'hF;
      frame_done_d = (select_q == SelTens);
    end

    // The code is sampled only here. Segments and dp then hold for the slot.
    if (capture) begin
      if (lz_blank && (select_q == SelTens) && (decimal_digit == 4'd0)) begin
        segments_d = 7'h7F;
      end else begin
        segments_d = encode(decimal_digit);
      end
      dp_d       = !(dp_enable && (select_q == SelOnes));
      digit_en_d = ~(4'b0001 << select_q);
    end

    // Enables stay dark while blank_all is asserted. After release they come
    // back only at a capture edge, because nothing else re-lights them.
    if (blank_all) begin
      digit_en_d = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      select_q     <= 2'd0;
      digit_en_q   <= 4'hF;
      segments_q   <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      select_q     <= select_d;
      digit_en_q   <= digit_en_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign select     = select_q;
  assign digit_en   = digit_en_q;
  assign segments   = segments_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int unsigned TickDiv = 8;
  localparam int unsigned Blank   = 2;
  localparam int unsigned CntW    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] decimal_digit;
  logic       lz_blank;
  logic       dp_enable;
  logic       blank_all;
  logic [1:0] select;
  logic [3:0] digit_en;
  logic [6:0] segments;
  logic       dp;
  logic       frame_done;

  // Upstream model: either a per-select code table or a directly forced code.
  logic       use_model;
  logic [3:0] dd_force;
  logic [3:0] model_code [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always_comb begin
    decimal_digit = dd_force;
    if (use_model) decimal_digit = model_code[select];
  end

  seg_scan_driver #(
    .TICK_DIV    (TickDiv),
    .BLANK_CYCLES(Blank),
    .CNT_W       (CntW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .decimal_digit(decimal_digit),
    .lz_blank     (lz_blank),
    .dp_enable    (dp_enable),
    .blank_all    (blank_all),
    .select       (select),
    .digit_en     (digit_en),
    .segments     (segments),
    .dp           (dp),
    .frame_done   (frame_done)
  );

  initial begin
    #100000;
    $display("FAIL watchdog timeout got cycle %0d expected finish", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL rst_select got %h expected 0", select); end
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL rst_en got %h expected F", digit_en); end
    checks++; if (segments !== 7'h7F) begin errors++; $display("FAIL rst_seg got %h expected 7F", segments); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp got %b expected 1", dp); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd got %b expected 0", frame_done); end
  endtask

  task automatic test_basic();
    use_model = 1'b0; dd_force = 4'd8;
    do_reset();
    tick();
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL basic_blank1 got %h expected F", digit_en); end
    tick();
    checks++; if (digit_en !== 4'hE) begin errors++; $display("FAIL basic_cap0_en got %h expected E", digit_en); end
    checks++; if (segments !== 7'h00) begin errors++; $display("FAIL basic_cap0_seg got %h expected 00", segments); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL basic_dp got %b expected 1", dp); end
    run_to(7);
    checks++; if (digit_en !== 4'hE) begin errors++; $display("FAIL basic_hold_en got %h expected E", digit_en); end
    tick();
    checks++; if (select !== 2'd1) begin errors++; $display("FAIL basic_sel1 got %h expected 1", select); end
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL basic_slot_dark got %h expected F", digit_en); end
    checks++; if (segments !== 7'h00) begin errors++; $display("FAIL basic_seg_hold got %h expected 00", segments); end
    tick();
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL basic_blank9 got %h expected F", digit_en); end
    tick();
    checks++; if (digit_en !== 4'hD) begin errors++; $display("FAIL basic_cap1_en got %h expected D", digit_en); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    int         pulses;
    exp_seg = '{7'h46, 7'h12, 7'h30, 7'h24};
    exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
    model_code = '{4'd10, 4'd5, 4'd3, 4'd2};
    use_model = 1'b1; dp_enable = 1'b1; lz_blank = 1'b0;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      run_to(8 * s + 2);
      checks++; if (segments !== exp_seg[s]) begin errors++; $display("FAIL scan_seg%0d got %h expected %h", s, segments, exp_seg[s]); end
      checks++; if (dp !== exp_dp[s]) begin errors++; $display("FAIL scan_dp%0d got %b expected %b", s, dp, exp_dp[s]); end
      checks++; if (digit_en !== ~(4'b0001 << s)) begin errors++; $display("FAIL scan_en%0d got %h expected %h", s, digit_en, ~(4'b0001 << s)); end
    end
    run_to(31);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL scan_fd31 got %b expected 0", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL scan_fd32 got %b expected 1", frame_done); end
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL scan_wrap_sel got %h expected 0", select); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL scan_fd33 got %b expected 0", frame_done); end
    pulses = 0;
    while (cyc < 64) begin
      tick();
      if (frame_done === 1'b1) pulses++;
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL scan_fd64 got %b expected 1", frame_done); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL scan_fd_count got %0d expected 1", pulses); end
    dp_enable = 1'b0;
  endtask

  task automatic test_lz();
    model_code = '{4'd1, 4'd2, 4'd3, 4'd0};
    use_model = 1'b1; lz_blank = 1'b1;
    do_reset();
    run_to(26);
    checks++; if (segments !== 7'h7F) begin errors++; $display("FAIL lz_on_seg got %h expected 7F", segments); end
    checks++; if (digit_en !== 4'h7) begin errors++; $display("FAIL lz_on_en got %h expected 7", digit_en); end
    lz_blank = 1'b0;
    run_to(58);
    checks++; if (segments !== 7'h40) begin errors++; $display("FAIL lz_off_seg got %h expected 40", segments); end
    // lz_blank applies to the tens digit only
    lz_blank = 1'b1; model_code[0] = 4'd0;
    run_to(66);
    checks++; if (segments !== 7'h40) begin errors++; $display("FAIL lz_unit_seg got %h expected 40", segments); end
    lz_blank = 1'b0;
  endtask

  task automatic test_capture();
    use_model = 1'b0; dd_force = 4'd1;
    do_reset();
    run_to(16);
    dd_force = 4'd7;
    run_to(18);
    checks++; if (segments !== 7'h78) begin errors++; $display("FAIL cap_blank_change got %h expected 78", segments); end
    checks++; if (digit_en !== 4'hB) begin errors++; $display("FAIL cap_en got %h expected B", digit_en); end
    tick();
    dd_force = 4'd1;
    run_to(23);
    checks++; if (segments !== 7'h78) begin errors++; $display("FAIL cap_drive_ignored got %h expected 78", segments); end
    run_to(50);
    checks++; if (segments !== 7'h79) begin errors++; $display("FAIL cap_next_frame got %h expected 79", segments); end
  endtask

  task automatic test_blank_all();
    use_model = 1'b0; dd_force = 4'd8;
    do_reset();
    run_to(3);
    blank_all = 1'b1;
    tick();
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL ba_assert got %h expected F", digit_en); end
    tick();
    blank_all = 1'b0;
    run_to(7);
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL ba_release_mid got %h expected F", digit_en); end
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL ba_sel7 got %h expected 0", select); end
    tick();
    checks++; if (select !== 2'd1) begin errors++; $display("FAIL ba_sel8 got %h expected 1", select); end
    tick();
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL ba_blank9 got %h expected F", digit_en); end
    tick();
    checks++; if (digit_en !== 4'hD) begin errors++; $display("FAIL ba_recapture got %h expected D", digit_en); end
  endtask

  task automatic test_reset_mid();
    use_model = 1'b0; dd_force = 4'd8;
    do_reset();
    run_to(27);
    checks++; if (digit_en !== 4'h7) begin errors++; $display("FAIL rm_pre_en got %h expected 7", digit_en); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc   = 0;
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL rm_select got %h expected 0", select); end
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL rm_en got %h expected F", digit_en); end
    checks++; if (segments !== 7'h7F) begin errors++; $display("FAIL rm_seg got %h expected 7F", segments); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rm_fd got %b expected 0", frame_done); end
    run_to(2);
    checks++; if (segments !== 7'h00) begin errors++; $display("FAIL rm_restart_seg got %h expected 00", segments); end
    dd_force = 4'd14;
    run_to(10);
    checks++; if (segments !== 7'h7F) begin errors++; $display("FAIL rm_code14 got %h expected 7F", segments); end
    dd_force = 4'd8;
    run_to(18);
    dd_force = 4'd15;
    run_to(26);
    checks++; if (segments !== 7'h7F) begin errors++; $display("FAIL rm_code15 got %h expected 7F", segments); end
  endtask

  task automatic test_encode();
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h46, 7'h09, 7'h79, 7'h7F, 7'h7F, 7'h7F};
    use_model = 1'b0; lz_blank = 1'b0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      run_to(8 * k);
      dd_force = 4'(k);
      run_to(8 * k + 2);
      checks++; if (segments !== tab[k]) begin errors++; $display("FAIL enc_code%0d got %h expected %h", k, segments, tab[k]); end
    end
  endtask

  initial begin
    reset = 1'b1; lz_blank = 1'b0; dp_enable = 1'b0; blank_all = 1'b0;
    use_model = 1'b0; dd_force = 4'd8;
    model_code = '{4'd0, 4'd0, 4'd0, 4'd0};
    test_reset();
    test_basic();
    test_scan();
    test_lz();
    test_capture();
    test_blank_all();
    test_reset_mid();
    test_encode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
